gear_selector: RTL and testbench
================================

# gear_selector

Upstream driver-input stage for the vehicle model. Debounces the shift-lever buttons and runs the P/R/N/D gear state machine with brake and speed interlocks. Classifies the brake-pedal ADC into normal and hard braking with hysteresis. Its `current_gear`, `is_brake_normal` and `is_brake_hard` outputs feed the vehicle physics/RPM stage directly; `speed` is fed back from that stage.

## Interface
Parameters:
- `DEB_MS`, 20: consecutive `tick_1ms` pulses a raw button level must hold before it is accepted.
- `LOCKOUT_MS`, 200: `tick_1ms` pulses after an accepted shift during which new requests are rejected.
- `BRK_N_ON`, 30: brake ADC value at or above which the normal-brake zone is entered.
- `BRK_N_OFF`, 20: brake ADC value below which the normal-brake zone is left.
- `BRK_H_ON`, 200: brake ADC value at or above which the hard-brake zone is entered.
- `BRK_H_OFF`, 180: brake ADC value below which the hard-brake zone is left.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `engine_on` in 1: engine running.
- `tick_1ms` in 1: one-cycle strobe, once per ms.
- `btn_up` in 1: raw shift-toward-P button, active high, asynchronous. Must be 2-flop synchronised.
- `btn_down` in 1: raw shift-toward-D button, same treatment as `btn_up`.
- `adc_brake` in 8: brake pedal position, 0 = released.
- `speed` in 8: vehicle speed in km/h, from the physics stage.
- `current_gear` out 4: 3 = P, 6 = R, 9 = N, 12 = D. Registered.
- `is_brake_normal` out 1: normal braking. Registered.
- `is_brake_hard` out 1: hard braking. Registered. Never high in the same cycle as `is_brake_normal`.
- `gear_changed` out 1: one-cycle pulse when `current_gear` updates.
- `shift_reject` out 1: one-cycle pulse when a shift request is refused.

## Operation
- **Reset values:** `current_gear` = 3 (P); all other outputs 0; debounce counters, debounced levels and lockout counter are all 0.
- **Debounce:**
  - On each `tick_1ms`: if the synchronised raw level differs from the debounced level, increment the counter; otherwise clear it.
  - When the counter reaches `DEB_MS`, the debounced level takes the raw level and the counter clears.
  - A 0→1 transition of the debounced level produces a one-cycle request (`req_up` or `req_down`). There is no auto-repeat.
- **Gear order:** P–R–N–D. `req_up` steps one position toward P; `req_down` steps one position toward D.
- **Interlocks:** a request is accepted only if all of the following hold:
  - `engine_on` = 1;
  - the lockout counter = 0;
  - the request is not at an end stop (up in P, down in D);
  - leaving P (P→R) requires `is_brake_normal` or `is_brake_hard`, and `speed` = 0;
  - entering P (R→P) requires `speed` = 0;
  - entering R (N→R) requires `speed` = 0;
  - R→N, N→D and D→N are always allowed.
- **Accepted request:** `current_gear` updates, `gear_changed` pulses, and the lockout counter loads `LOCKOUT_MS`. The counter decrements on each `tick_1ms` until it reaches 0.
- **Refused request:** `shift_reject` pulses and the gear is held.
- **Simultaneous requests:** `req_up` and `req_down` in the same cycle are both refused, with a single `shift_reject` pulse.
- **Engine off:** if `current_gear` ≠ P and `speed` = 0, the block forces P, pulses `gear_changed`, and clears the lockout. Any request while the engine is off is refused.
- **Brake classification:**
  - Hard zone: set when `adc_brake` ≥ `BRK_H_ON`; cleared when `adc_brake` < `BRK_H_OFF`.
  - Normal zone: set when `adc_brake` ≥ `BRK_N_ON`; cleared when `adc_brake` < `BRK_N_OFF`.
  - `is_brake_hard` = hard zone; `is_brake_normal` = normal zone AND NOT hard zone.
  - Classification is evaluated every clock, independent of `engine_on`.
- **Interlock brake source:** interlocks use the registered brake outputs, i.e. the values from the previous cycle.

## Timing
- **Button latency:** from a raw edge to the request is 2 clocks (synchroniser) plus `DEB_MS` ticks plus 1 clock.
- **Shift latency:** from the request to `current_gear` updating is 1 clock. `gear_changed` is asserted in the same cycle as the new gear value.
- **Brake latency:** from `adc_brake` to the brake outputs is 1 clock.
- **Lockout window:** a request is rejected while the counter is nonzero, including the cycle in which the counter's final decrement occurs.
- **Reset mid-operation:** asynchronous return to the reset values. Any pending debounce or lockout state is discarded.

## Structure
- **Shared package (`vehicle_pkg`):**
  - gear codes `GEAR_P`/`GEAR_R`/`GEAR_N`/`GEAR_D` (3/6/9/12);
  - brake threshold defaults;
  - the 1 ms tick definition.
  - The physics/RPM stage uses the same gear constants.
- **Sub-module `btn_debounce`:** synchroniser, counter, debounced level and rise-pulse output, instantiated twice (`btn_up`, `btn_down`).
- **Top level:** gear FSM, lockout counter and brake hysteresis.

## Test plan
- **Reset and engine start:** reset, then `engine_on` = 1 → `current_gear` = 3, no pulses.
- **Leaving P without brake:** `adc_brake` = 0, `speed` = 0, `btn_down` held 25 ms → `shift_reject` pulse, gear stays 3. Repeat with `adc_brake` = 50 → gear = 6 and a `gear_changed` pulse.
- **Bounce and lockout:** `btn_down` toggling every 5 ms for 40 ms, then held 25 ms → exactly one step (R→N). A second press 100 ms later → rejected (lockout). A press 250 ms later → N→D.
- **Speed interlock:** gear D, `speed` = 40, press up → N accepted. Press up again → rejected (`speed` ≠ 0). Set `speed` = 0, press up → R.
- **Brake hysteresis:**
  - ramp `adc_brake` 0→255: normal asserts at 30 and hands over to hard at 200;
  - ramp down: hard held until 179, then normal;
  - normal held until 19, then both 0;
  - the two outputs are never high together.
- **Engine off:** `engine_on` falls in D with `speed` = 0 → gear = 3 next clock with a `gear_changed` pulse. Button presses while off → `shift_reject`. Apply `rst_n` low during lockout → all outputs reset immediately.

Source files
------------

// File: rtl/vehicle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vehicle_pkg
// Description : Constants shared by the vehicle model stages: gear codes,
//               default brake-classification thresholds and the 1 ms tick
//               definition. The physics/RPM stage relies on the same gear
//               encoding, so the values must not change.
// Revision    : 1.0 - initial release
// ============================================================================
package vehicle_pkg;

  // Gear encoding seen on current_gear. Non-contiguous codes so that a
  // single-bit upset never lands on another legal gear.
  typedef enum logic [3:0] {
    GEAR_P = 4'd3,
    GEAR_R = 4'd6,
    GEAR_N = 4'd9,
    GEAR_D = 4'd12
  } gear_t;

  // Default brake ADC thresholds (8-bit pedal position, 0 = released).
  localparam int C_BRK_N_ON  = 30;
  localparam int C_BRK_N_OFF = 20;
  localparam int C_BRK_H_ON  = 200;
  localparam int C_BRK_H_OFF = 180;

  // The 1 ms tick is a single-cycle strobe generated once every
  // C_TICK_1MS_CYCLES system clocks by the timebase block.
  localparam int C_CLK_HZ          = 50_000_000;
  localparam int C_TICK_1MS_CYCLES = C_CLK_HZ / 1000;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchroniser, tick-based debounce counter, debounced
//               level and a one-cycle rise pulse for a raw push button.
// Ports       : clk, rst_n       - clock, asynchronous active-low reset
//               tick_1ms         - one-cycle strobe per millisecond
//               btn_raw          - asynchronous raw button level
//               level            - debounced level (registered)
//               rise             - one-cycle pulse on a 0->1 debounced edge
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DEB_MS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_1ms,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEB_MS + 1);
  // The accepting tick is the one that would bring the counter to DEB_MS.
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEB_MS - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], btn_raw};
      r_rise <= 1'b0;
      if (tick_1ms) begin
        if (r_sync[1] != r_level) begin
          if (r_cnt == C_CNT_LAST) begin
            r_level <= r_sync[1];
            r_cnt   <= '0;
            r_rise  <= r_sync[1];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          // Any tick where the level agrees restarts the qualification.
          r_cnt <= '0;
        end
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/gear_selector.sv
`default_nettype none
// ============================================================================
// Module      : gear_selector
// Description : Driver-input stage. Debounces the shift buttons, runs the
//               P/R/N/D gear state machine with brake/speed/engine interlocks
//               and a post-shift lockout, and classifies the brake ADC into
//               normal and hard braking with hysteresis.
// Ports       : clk, rst_n           - clock, asynchronous active-low reset
//               engine_on            - engine running
//               tick_1ms             - one-cycle strobe per millisecond
//               btn_up, btn_down     - raw shift buttons (toward P / toward D)
//               adc_brake[7:0]       - brake pedal position
//               speed[7:0]           - vehicle speed, km/h
//               current_gear[3:0]    - 3=P 6=R 9=N 12=D (registered)
//               is_brake_normal/hard - brake classification (registered)
//               gear_changed         - pulse when current_gear updates
//               shift_reject         - pulse when a request is refused
// Revision    : 1.0 - initial release
// ============================================================================
module gear_selector
  import vehicle_pkg::*;
#(
  parameter int DEB_MS     = 20,
  parameter int LOCKOUT_MS = 200,
  parameter int BRK_N_ON   = C_BRK_N_ON,
  parameter int BRK_N_OFF  = C_BRK_N_OFF,
  parameter int BRK_H_ON   = C_BRK_H_ON,
  parameter int BRK_H_OFF  = C_BRK_H_OFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       engine_on,
  input  logic       tick_1ms,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [7:0] adc_brake,
  input  logic [7:0] speed,
  output logic [3:0] current_gear,
  output logic       is_brake_normal,
  output logic       is_brake_hard,
  output logic       gear_changed,
  output logic       shift_reject
);

  localparam int LOCK_W = $clog2(LOCKOUT_MS + 1);
  localparam logic [LOCK_W-1:0] C_LOCK_LOAD = LOCK_W'(LOCKOUT_MS);

  // --------------------------------------------------------------------------
  // Button conditioning
  // --------------------------------------------------------------------------
  logic w_up_level;
  logic w_down_level;
  logic w_req_up;
  logic w_req_down;

  btn_debounce #(.DEB_MS(DEB_MS)) u_deb_up (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_1ms (tick_1ms),
    .btn_raw  (btn_up),
    .level    (w_up_level),
    .rise     (w_req_up)
  );

  btn_debounce #(.DEB_MS(DEB_MS)) u_deb_down (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_1ms (tick_1ms),
    .btn_raw  (btn_down),
    .level    (w_down_level),
    .rise     (w_req_down)
  );

  // --------------------------------------------------------------------------
  // Brake classification with hysteresis
  // --------------------------------------------------------------------------
  logic r_hard_zone;
  logic r_norm_zone;
  logic r_brake_normal;
  logic r_brake_hard;
  logic w_hard_next;
  logic w_norm_next;

  always_comb begin
    w_hard_next = r_hard_zone;
    if (adc_brake >= 8'(BRK_H_ON)) begin
      w_hard_next = 1'b1;
    end else if (adc_brake < 8'(BRK_H_OFF)) begin
      w_hard_next = 1'b0;
    end
    w_norm_next = r_norm_zone;
    if (adc_brake >= 8'(BRK_N_ON)) begin
      w_norm_next = 1'b1;
    end else if (adc_brake < 8'(BRK_N_OFF)) begin
      w_norm_next = 1'b0;
    end
  end

  // Outputs are registered from the next-zone values so the ADC-to-output
  // latency is a single clock, and hard always masks normal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hard_zone    <= 1'b0;
      r_norm_zone    <= 1'b0;
      r_brake_hard   <= 1'b0;
      r_brake_normal <= 1'b0;
    end else begin
      r_hard_zone    <= w_hard_next;
      r_norm_zone    <= w_norm_next;
      r_brake_hard   <= w_hard_next;
      r_brake_normal <= w_norm_next & ~w_hard_next;
    end
  end

  // --------------------------------------------------------------------------
  // Gear state machine and lockout
  // --------------------------------------------------------------------------
  gear_t             r_gear;
  logic [LOCK_W-1:0] r_lock;
  logic              r_gear_changed;
  logic              r_shift_reject;

  logic  w_spd0;
  logic  w_brake_ok;
  logic  w_up_ok;
  logic  w_down_ok;
  gear_t w_up_gear;
  gear_t w_down_gear;

  // Target gear and gear/speed/brake admissibility for each direction.
  // The brake term uses the registered (previous-cycle) classification.
  always_comb begin
    w_spd0      = (speed == 8'd0);
    w_brake_ok  = r_brake_normal | r_brake_hard;
    w_up_ok     = 1'b0;
    w_up_gear   = r_gear;
    w_down_ok   = 1'b0;
    w_down_gear = r_gear;
    case (r_gear)
      GEAR_P: begin
        w_down_gear = GEAR_R;
        w_down_ok   = w_brake_ok & w_spd0;
      end
      GEAR_R: begin
        w_up_gear   = GEAR_P;
        w_up_ok     = w_spd0;
        w_down_gear = GEAR_N;
        w_down_ok   = 1'b1;
      end
      GEAR_N: begin
        w_up_gear   = GEAR_R;
        w_up_ok     = w_spd0;
        w_down_gear = GEAR_D;
        w_down_ok   = 1'b1;
      end
      GEAR_D: begin
        w_up_gear   = GEAR_N;
        w_up_ok     = 1'b1;
      end
      default: begin
        w_up_ok   = 1'b0;
        w_down_ok = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gear         <= GEAR_P;
      r_lock         <= '0;
      r_gear_changed <= 1'b0;
      r_shift_reject <= 1'b0;
    end else begin
      r_gear_changed <= 1'b0;
      r_shift_reject <= 1'b0;

      if (tick_1ms && (r_lock != '0)) begin
        r_lock <= r_lock - 1'b1;
      end

      if (!engine_on) begin
        // Stationary with the engine off: park the vehicle.
        if ((r_gear != GEAR_P) && w_spd0) begin
          r_gear         <= GEAR_P;
          r_gear_changed <= 1'b1;
          r_lock         <= '0;
        end
        if (w_req_up || w_req_down) begin
          r_shift_reject <= 1'b1;
        end
      end else if (w_req_up && w_req_down) begin
        r_shift_reject <= 1'b1;
      end else if (w_req_up) begin
        // Lockout is checked on the pre-decrement value, so the cycle of the
        // final decrement still rejects.
        if ((r_lock == '0) && w_up_ok) begin
          r_gear         <= w_up_gear;
          r_gear_changed <= 1'b1;
          r_lock         <= C_LOCK_LOAD;
        end else begin
          r_shift_reject <= 1'b1;
        end
      end else if (w_req_down) begin
        if ((r_lock == '0) && w_down_ok) begin
          r_gear         <= w_down_gear;
          r_gear_changed <= 1'b1;
          r_lock         <= C_LOCK_LOAD;
        end else begin
          r_shift_reject <= 1'b1;
        end
      end
    end
  end

  assign current_gear    = r_gear;
  assign is_brake_normal = r_brake_normal;
  assign is_brake_hard   = r_brake_hard;
  assign gear_changed    = r_gear_changed;
  assign shift_reject    = r_shift_reject;

  // Debounced levels are only needed for their rise pulses here.
  logic w_unused;
  assign w_unused = w_up_level ^ w_down_level;

endmodule
`default_nettype wire

// File: tb/tb_gear_selector.sv
`default_nettype none
// ============================================================================
// Module      : tb_gear_selector
// Description : Directed self-checking bench for gear_selector. One ms is
//               ten clock cycles of the bench timebase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gear_selector;

  localparam int C_MS = 10;

  logic       clk;
  logic       rst_n;
  logic       engine_on;
  logic       tick_1ms;
  logic       btn_up;
  logic       btn_down;
  logic [7:0] adc_brake;
  logic [7:0] speed;
  logic [3:0] current_gear;
  logic       is_brake_normal;
  logic       is_brake_hard;
  logic       gear_changed;
  logic       shift_reject;

  int n_checks = 0;
  int n_errors = 0;
  int n_chg    = 0;
  int n_rej    = 0;
  int n_both   = 0;

  gear_selector dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .engine_on       (engine_on),
    .tick_1ms        (tick_1ms),
    .btn_up          (btn_up),
    .btn_down        (btn_down),
    .adc_brake       (adc_brake),
    .speed           (speed),
    .current_gear    (current_gear),
    .is_brake_normal (is_brake_normal),
    .is_brake_hard   (is_brake_hard),
    .gear_changed    (gear_changed),
    .shift_reject    (shift_reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1 ms strobe: one clock high every C_MS clocks.
  initial begin
    tick_1ms = 1'b0;
    forever begin
      repeat (C_MS - 1) @(negedge clk);
      tick_1ms = 1'b1;
      @(negedge clk);
      tick_1ms = 1'b0;
    end
  end

  // Pulse and exclusivity monitors.
  always @(negedge clk) begin
    if (rst_n) begin
      if (gear_changed) n_chg++;
      if (shift_reject) n_rej++;
      if (is_brake_normal && is_brake_hard) n_both++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ms(input int ms);
    repeat (ms * C_MS) @(negedge clk);
  endtask

  // Press a button for hold_ms, then release it long enough to debounce.
  task automatic press(input bit up, input int hold_ms);
    @(negedge clk);
    if (up) btn_up = 1'b1; else btn_down = 1'b1;
    wait_ms(hold_ms);
    if (up) btn_up = 1'b0; else btn_down = 1'b0;
    wait_ms(25);
  endtask

  int chg0;
  int rej0;

  initial begin
    rst_n     = 1'b0;
    engine_on = 1'b0;
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    adc_brake = 8'd0;
    speed     = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_gear", current_gear, 3);
    check("reset_normal", is_brake_normal, 0);
    check("reset_hard", is_brake_hard, 0);
    check("reset_changed", gear_changed, 0);
    check("reset_reject", shift_reject, 0);

    // Engine start
    rst_n = 1'b1;
    engine_on = 1'b1;
    wait_ms(2);
    check("start_gear", current_gear, 3);
    check("start_pulses", n_chg + n_rej, 0);

    // Leaving P without brake, then with brake
    chg0 = n_chg; rej0 = n_rej;
    press(1'b0, 25);
    check("p_nobrake_reject", n_rej - rej0, 1);
    check("p_nobrake_gear", current_gear, 3);
    check("p_nobrake_changed", n_chg - chg0, 0);
    adc_brake = 8'd50;
    wait_ms(1);
    chg0 = n_chg; rej0 = n_rej;
    press(1'b0, 25);
    check("p_brake_gear", current_gear, 6);
    check("p_brake_changed", n_chg - chg0, 1);
    check("p_brake_reject", n_rej - rej0, 0);

    // Bounce then hold: exactly one step R->N
    wait_ms(250);
    chg0 = n_chg; rej0 = n_rej;
    for (int i = 0; i < 8; i++) begin
      btn_down = ~btn_down;
      wait_ms(5);
    end
    press(1'b0, 25);
    check("bounce_gear", current_gear, 9);
    check("bounce_changed", n_chg - chg0, 1);
    check("bounce_reject", n_rej - rej0, 0);

    // Press inside lockout
    wait_ms(50);
    rej0 = n_rej;
    press(1'b0, 25);
    check("lockout_reject", n_rej - rej0, 1);
    check("lockout_gear", current_gear, 9);

    // Press after lockout expiry
    wait_ms(200);
    press(1'b0, 25);
    check("after_lockout_gear", current_gear, 12);

    // Speed interlock
    wait_ms(250);
    speed = 8'd40;
    press(1'b1, 25);
    check("spd_d_to_n", current_gear, 9);
    wait_ms(250);
    rej0 = n_rej;
    press(1'b1, 25);
    check("spd_n_to_r_reject", n_rej - rej0, 1);
    check("spd_n_to_r_gear", current_gear, 9);
    speed = 8'd0;
    press(1'b1, 25);
    check("spd0_n_to_r", current_gear, 6);

    // Brake hysteresis ramps
    for (int v = 0; v < 256; v++) begin
      @(negedge clk);
      adc_brake = 8'(v);
      @(posedge clk); #1;
      check($sformatf("up_hard_%0d", v), is_brake_hard, (v >= 200) ? 1 : 0);
      check($sformatf("up_norm_%0d", v), is_brake_normal, (v >= 30 && v < 200) ? 1 : 0);
    end
    for (int v = 255; v >= 0; v--) begin
      @(negedge clk);
      adc_brake = 8'(v);
      @(posedge clk); #1;
      check($sformatf("dn_hard_%0d", v), is_brake_hard, (v >= 180) ? 1 : 0);
      check($sformatf("dn_norm_%0d", v), is_brake_normal, (v >= 20 && v < 180) ? 1 : 0);
    end
    check("brake_exclusive", n_both, 0);

    // Reach D, then engine off
    wait_ms(250);
    press(1'b0, 25);
    wait_ms(250);
    press(1'b0, 25);
    check("engoff_pre_gear", current_gear, 12);
    @(negedge clk);
    engine_on = 1'b0;
    @(posedge clk); #1;
    check("engoff_gear", current_gear, 3);
    check("engoff_changed", gear_changed, 1);
    rej0 = n_rej;
    press(1'b0, 25);
    check("engoff_press_reject", n_rej - rej0, 1);
    check("engoff_press_gear", current_gear, 3);

    // Reset during lockout
    engine_on = 1'b1;
    adc_brake = 8'd50;
    wait_ms(1);
    press(1'b0, 25);
    check("prerst_gear", current_gear, 6);
    check("prerst_normal", is_brake_normal, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_gear", current_gear, 3);
    check("async_rst_normal", is_brake_normal, 0);
    check("async_rst_hard", is_brake_hard, 0);
    check("async_rst_changed", gear_changed, 0);
    check("async_rst_reject", shift_reject, 0);
    wait_ms(1);
    rst_n = 1'b1;
    wait_ms(1);
    chg0 = n_chg; rej0 = n_rej;
    press(1'b0, 25);
    check("postrst_no_lockout_gear", current_gear, 6);
    check("postrst_reject", n_rej - rej0, 0);
    check("postrst_changed", n_chg - chg0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
